// File: rtl/branch_decode_unit.sv
// branch_decode_unit: registered instruction decoder with branch squash, return-address stack and sticky stack fault
module branch_decode_unit #(
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 iValid,
    input  logic                                 iStall,
    input  logic [INSTR_WIDTH-1:0]               wInstruction,
    input  logic [ADDR_WIDTH-1:0]                wPC,
    input  logic                                 wZa,
    input  logic                                 wZb,
    input  logic                                 wCa,
    input  logic                                 wCb,
    input  logic                                 wNa,
    input  logic                                 wNb,
    output logic                                 oValid,
    output logic                                 rBranch_taken,
    output logic [ADDR_WIDTH-1:0]                rBranch_dir,
    output logic [DATA_WIDTH-1:0]                rC,
    output logic                                 rMux_a_sel,
    output logic                                 rMux_b_sel,
    output logic                                 rFault,
    output logic [1:0]                           rFault_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     oStack_count
);
    localparam int CW = $clog2(STACK_DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);
    localparam logic [5:0] OP_JMP = 6'h20, OP_CALL = 6'h2D, OP_RET = 6'h2E;

    typedef enum logic [1:0] {RUN, SQUASH, FAULT} stateType;
    stateType state, nState;

    // Sized to the full count range so every count value is a legal index.
    logic [ADDR_WIDTH-1:0] stackMem [2**CW];

    logic [5:0]            op;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] target, retAddr;
    logic [CW-1:0]         popIdx, nCount;
    logic [3:0]            condIdx;
    logic [11:0]           condVec;
    logic                  isImm, isCond, doPush;
    logic                  nValid, nTaken, nMuxA, nMuxB, nFault;
    logic [ADDR_WIDTH-1:0] nDir;
    logic [DATA_WIDTH-1:0] nC;
    logic [1:0]            nCode;

    assign op      = wInstruction[INSTR_WIDTH-1 -: 6];
    assign imm     = wInstruction[DATA_WIDTH-1:0];
    assign target  = wInstruction[ADDR_WIDTH-1:0];
    assign popIdx  = oStack_count - CW'(1);
    assign retAddr = wPC + ADDR_WIDTH'(1);
    assign isImm   = op >= 6'h10 && op <= 6'h19;
    assign isCond  = op >= 6'h21 && op <= 6'h2C;
    assign condIdx = op[3:0] - 4'd1;
    // Bit k holds the condition of opcode 6'h21+k: Z/C/N set then clear, A flags then B flags.
    assign condVec = {~wNb, wNb, ~wCb, wCb, ~wZb, wZb, ~wNa, wNa, ~wCa, wCa, ~wZa, wZa};

    always_comb begin
        nValid = 1'b0;
        nTaken = 1'b0;
        nDir   = '0;
        nC     = '0;
        nMuxA  = 1'b0;
        nMuxB  = 1'b0;
        nFault = rFault;
        nCode  = rFault_code;
        nCount = oStack_count;
        nState = state;
        doPush = 1'b0;
        if (state == RUN && iValid) begin
            if (op == OP_CALL && oStack_count == FULL) begin
                nFault = 1'b1;
                nCode  = 2'b01;
                nState = FAULT;
            end else if (op == OP_RET && oStack_count == '0) begin
                nFault = 1'b1;
                nCode  = 2'b10;
                nState = FAULT;
            end else begin
                nValid = 1'b1;
                nC     = isImm ? imm : '0;
                nMuxA  = isImm && (op[0] ? op != 6'h11 : op == 6'h10);
                nMuxB  = isImm && !nMuxA;
                nTaken = op == OP_JMP || op == OP_CALL || op == OP_RET || (isCond && condVec[condIdx]);
                nDir   = !nTaken ? '0 : op == OP_RET ? stackMem[popIdx] : target;
                nCount = op == OP_CALL ? oStack_count + CW'(1) : op == OP_RET ? popIdx : oStack_count;
                doPush = op == OP_CALL;
                nState = nTaken ? SQUASH : RUN;
            end
        end else if (state == SQUASH) begin
            nState = RUN;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= RUN;
            oValid        <= 1'b0;
            rBranch_taken <= 1'b0;
            rBranch_dir   <= '0;
            rC            <= '0;
            rMux_a_sel    <= 1'b0;
            rMux_b_sel    <= 1'b0;
            rFault        <= 1'b0;
            rFault_code   <= 2'b00;
            oStack_count  <= '0;
        end else if (!iStall) begin
            state         <= nState;
            oValid        <= nValid;
            rBranch_taken <= nTaken;
            rBranch_dir   <= nDir;
            rC            <= nC;
            rMux_a_sel    <= nMuxA;
            rMux_b_sel    <= nMuxB;
            rFault        <= nFault;
            rFault_code   <= nCode;
            oStack_count  <= nCount;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && !iStall && doPush) stackMem[oStack_count] <= retAddr;
    end
endmodule

// File: tb/tb_branch_decode_unit.sv
// tb_branch_decode_unit: directed checks of decode, squash, call/return stack, stall and faults
module tb_branch_decode_unit;
    logic       Clock = 1'b0;
    logic       Reset, iValid, iStall;
    logic [15:0] wInstruction;
    logic [9:0] wPC;
    logic       wZa, wZb, wCa, wCb, wNa, wNb;
    logic       oValid, rBranch_taken, rMux_a_sel, rMux_b_sel, rFault;
    logic [9:0] rBranch_dir;
    logic [7:0] rC;
    logic [1:0] rFault_code;
    logic [2:0] oStack_count;
    int total = 0;
    int fails = 0;

    branch_decode_unit dut (
        .Clock(Clock), .Reset(Reset), .iValid(iValid), .iStall(iStall),
        .wInstruction(wInstruction), .wPC(wPC),
        .wZa(wZa), .wZb(wZb), .wCa(wCa), .wCb(wCb), .wNa(wNa), .wNb(wNb),
        .oValid(oValid), .rBranch_taken(rBranch_taken), .rBranch_dir(rBranch_dir),
        .rC(rC), .rMux_a_sel(rMux_a_sel), .rMux_b_sel(rMux_b_sel),
        .rFault(rFault), .rFault_code(rFault_code), .oStack_count(oStack_count)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] enc(input logic [5:0] op, input logic [9:0] low);
        return {op, low};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic [9:0] pc);
        iValid = v;
        wInstruction = ins;
        wPC = pc;
        @(posedge Clock);
        #1;
    endtask

    task automatic outs(input string tag, input logic v, input logic t, input logic [9:0] d,
                        input logic [7:0] c, input logic ma, input logic mb);
        chk({tag, ".valid"}, 32'(oValid), 32'(v));
        chk({tag, ".taken"}, 32'(rBranch_taken), 32'(t));
        chk({tag, ".dir"}, 32'(rBranch_dir), 32'(d));
        chk({tag, ".c"}, 32'(rC), 32'(c));
        chk({tag, ".muxa"}, 32'(rMux_a_sel), 32'(ma));
        chk({tag, ".muxb"}, 32'(rMux_b_sel), 32'(mb));
    endtask

    task automatic status(input string tag, input logic f, input logic [1:0] code, input logic [2:0] cnt);
        chk({tag, ".fault"}, 32'(rFault), 32'(f));
        chk({tag, ".code"}, 32'(rFault_code), 32'(code));
        chk({tag, ".count"}, 32'(oStack_count), 32'(cnt));
    endtask

    task automatic doReset();
        Reset = 1'b1;
        step(1'b0, 16'h0, 10'h0);
        step(1'b0, 16'h0, 10'h0);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; iValid = 1'b0; iStall = 1'b0; wInstruction = '0; wPC = '0;
        {wZa, wZb, wCa, wCb, wNa, wNb} = '0;
        // Put junk in first so reset has something to clear.
        Reset = 1'b0;
        step(1'b1, enc(6'h10, 10'h0AA), 10'h0);
        doReset();
        outs("reset", 0, 0, 10'h0, 8'h00, 0, 0);
        status("reset", 0, 2'b00, 3'd0);

        step(1'b1, 16'h405A, 10'h001);
        outs("ldca", 1, 0, 10'h0, 8'h5A, 1, 0);
        step(1'b1, enc(6'h11, 10'h0C3), 10'h002);
        outs("ldcb", 1, 0, 10'h0, 8'hC3, 0, 1);
        step(1'b1, enc(6'h13, 10'h00F), 10'h003);
        outs("addcb", 1, 0, 10'h0, 8'h0F, 1, 0);
        step(1'b1, enc(6'h14, 10'h381), 10'h004);
        outs("subca", 1, 0, 10'h0, 8'h81, 0, 1);

        wZa = 1'b1;
        step(1'b1, enc(6'h21, 10'h033), 10'h005);
        outs("baeq_t", 1, 1, 10'h033, 8'h00, 0, 0);
        step(1'b1, enc(6'h10, 10'h077), 10'h006);
        outs("squash", 0, 0, 10'h0, 8'h00, 0, 0);
        step(1'b1, enc(6'h10, 10'h022), 10'h033);
        outs("after_sq", 1, 0, 10'h0, 8'h22, 1, 0);
        wZa = 1'b0;
        step(1'b1, enc(6'h21, 10'h033), 10'h034);
        outs("baeq_nt", 1, 0, 10'h0, 8'h00, 0, 0);
        step(1'b1, enc(6'h11, 10'h044), 10'h035);
        outs("no_squash", 1, 0, 10'h0, 8'h44, 0, 1);

        wNb = 1'b1; wCa = 1'b1;
        step(1'b1, enc(6'h2B, 10'h155), 10'h036);
        outs("bbmi_t", 1, 1, 10'h155, 8'h00, 0, 0);
        step(1'b0, 16'h0, 10'h037);
        outs("sq_noval", 0, 0, 10'h0, 8'h00, 0, 0);
        step(1'b1, enc(6'h24, 10'h155), 10'h155);
        outs("bacc_nt", 1, 0, 10'h0, 8'h00, 0, 0);
        step(1'b1, enc(6'h2C, 10'h0F0), 10'h156);
        outs("bbpl_nt", 1, 0, 10'h0, 8'h00, 0, 0);
        wNb = 1'b0; wCa = 1'b0;
        step(1'b1, enc(6'h3F, 10'h3FF), 10'h157);
        outs("unknown", 1, 0, 10'h0, 8'h00, 0, 0);
        step(1'b0, enc(6'h10, 10'h011), 10'h158);
        outs("novalid", 0, 0, 10'h0, 8'h00, 0, 0);

        step(1'b1, enc(6'h2D, 10'h100), 10'h3FF);
        outs("call", 1, 1, 10'h100, 8'h00, 0, 0);
        status("call", 0, 2'b00, 3'd1);
        step(1'b1, 16'h0, 10'h000);
        chk("call_sq.valid", 32'(oValid), 0);
        step(1'b1, enc(6'h2E, 10'h000), 10'h100);
        outs("ret", 1, 1, 10'h000, 8'h00, 0, 0);
        status("ret", 0, 2'b00, 3'd0);
        step(1'b0, 16'h0, 10'h0);

        step(1'b1, 16'h405A, 10'h010);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, enc(6'h20, 10'h2AA), 10'h011);
            outs("stall_hold", 1, 0, 10'h0, 8'h5A, 1, 0);
        end
        iStall = 1'b0;
        step(1'b1, enc(6'h20, 10'h2AA), 10'h011);
        outs("jmp", 1, 1, 10'h2AA, 8'h00, 0, 0);
        iStall = 1'b1;
        step(1'b1, enc(6'h10, 10'h066), 10'h2AA);
        outs("stall_sq", 1, 1, 10'h2AA, 8'h00, 0, 0);
        iStall = 1'b0;
        step(1'b1, enc(6'h10, 10'h066), 10'h2AA);
        outs("sq_after_stall", 0, 0, 10'h0, 8'h00, 0, 0);
        step(1'b1, enc(6'h10, 10'h067), 10'h2AB);
        outs("run_after", 1, 0, 10'h0, 8'h67, 1, 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, enc(6'h2D, 10'(12'h200 + i)), 10'(i));
            chk("push.count", 32'(oStack_count), 32'(i + 1));
            step(1'b0, 16'h0, 10'h0);
        end
        step(1'b1, enc(6'h2D, 10'h300), 10'h004);
        outs("ovf", 0, 0, 10'h0, 8'h00, 0, 0);
        status("ovf", 1, 2'b01, 3'd4);
        step(1'b1, 16'h405A, 10'h005);
        outs("fault_hold", 0, 0, 10'h0, 8'h00, 0, 0);
        status("fault_hold", 1, 2'b01, 3'd4);
        step(1'b1, enc(6'h2E, 10'h0), 10'h006);
        outs("fault_ret", 0, 0, 10'h0, 8'h00, 0, 0);
        doReset();
        status("fault_clr", 0, 2'b00, 3'd0);

        step(1'b1, enc(6'h2E, 10'h0), 10'h020);
        outs("unf", 0, 0, 10'h0, 8'h00, 0, 0);
        status("unf", 1, 2'b10, 3'd0);
        doReset();
        step(1'b1, 16'h405A, 10'h001);
        outs("post_reset", 1, 0, 10'h0, 8'h5A, 1, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
